a2d_sched: RTL and testbench

A2D_SCHED -- requirements
Module: a2d_sched

---
 rtl/a2d_sched_pkg.sv | 35 +++
 rtl/a2d_sched_batt_filt.sv | 35 +++
 rtl/a2d_sched.sv | 117 +++++++++++
 tb/tb_a2d_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_sched_pkg.sv
// A2D conversion scheduler: shared states, channel codes and cmd layout.
package a2d_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX1,
        GAP,
        TX2,
        UPD
    } state_t;

    localparam int CH_W  = 3;
    localparam int PAD_W = 2;
    localparam int LO_W  = 11;

    localparam logic [CH_W-1:0] CH_LFT  = 3'd0;
    localparam logic [CH_W-1:0] CH_RGHT = 3'd4;
    localparam logic [CH_W-1:0] CH_BATT = 3'd5;

    function automatic logic [15:0] mk_cmd(input logic [CH_W-1:0] ch);
        return {{PAD_W{1'b0}}, ch, {LO_W{1'b0}}};
    endfunction

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        logic [CH_W-1:0] n;
        n = CH_LFT;
        unique case (1'b1)
            (ch == CH_LFT):  n = CH_RGHT;
            (ch == CH_RGHT): n = CH_BATT;
            default:         n = CH_LFT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/a2d_sched_batt_filt.sv
// Battery 4-sample running average, used only with A2D_SCHED_BATT_FILT_EN.
module a2d_batt_filt #(
    parameter logic [11:0] BATT_THRES = 12'h800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [11:0] smp,
    output logic [11:0] avg,
    output logic        low
);

    logic [11:0] q [4];
    logic [13:0] sum;
    logic [13:0] sum_n;

    assign sum   = 14'(q[0]) + 14'(q[1]) + 14'(q[2]) + 14'(q[3]);
    // Window after this write, so low tracks the value avg will show.
    assign sum_n = 14'(smp) + 14'(q[0]) + 14'(q[1]) + 14'(q[2]);
    assign avg   = sum[13:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) q[i] <= 12'hFFF;
            low <= 1'b0;
        end else if (wr) begin
            q[0] <= smp;
            q[1] <= q[0];
            q[2] <= q[1];
            q[3] <= q[2];
            low  <= (sum_n[13:2] < BATT_THRES);
        end
    end

endmodule

// File: rtl/a2d_sched.sv
// Round-robin A2D scheduler: two SPI transactions per channel conversion.
// Optional battery averaging filter enabled by A2D_SCHED_BATT_FILT_EN.
module a2d_sched
    import a2d_sched_pkg::*;
#(
    parameter logic [11:0] BATT_THRES = 12'h800,
    parameter int          GAP_CYC    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        batt_low,
    output logic        busy
);

    state_t          state, state_n;
    logic [3:0]      gap_cnt, gap_cnt_n;
    logic [CH_W-1:0] ch, ch_n;
    logic            wrt_n;
    logic [11:0]     res;
    logic            batt_wr;
    logic            unused_hi;

    assign unused_hi = ^rd_data[15:12];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= 4'd0;
            ch      <= CH_LFT;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_cnt_n;
            ch      <= ch_n;
        end
    end

    always_comb begin
        state_n   = state;
        gap_cnt_n = gap_cnt;
        ch_n      = ch;
        wrt_n     = 1'b0;
        unique case (state)
            IDLE: if (nxt) begin
                state_n = TX1;
                wrt_n   = 1'b1;
            end
            TX1: if (done) begin
                state_n   = GAP;
                gap_cnt_n = 4'd0;
            end
            GAP: if (gap_cnt == 4'(GAP_CYC - 1)) begin
                state_n = TX2;
                wrt_n   = 1'b1;
            end else begin
                gap_cnt_n = gap_cnt + 4'd1;
            end
            TX2: if (done) state_n = UPD;
            UPD: begin
                state_n = IDLE;
                ch_n    = next_ch(ch);
            end
            default: state_n = IDLE;
        endcase
    end

    assign batt_wr = (state == UPD) && (ch == CH_BATT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrt     <= 1'b0;
            cmd     <= 16'h0000;
            busy    <= 1'b0;
            res     <= 12'h000;
            lft_ld  <= 12'h000;
            rght_ld <= 12'h000;
        end else begin
            wrt  <= wrt_n;
            busy <= (state_n != IDLE);
            if (state == IDLE && nxt) cmd <= mk_cmd(ch);
            if (state == TX2 && done) res <= rd_data[11:0];
            if (state == UPD && ch == CH_LFT) lft_ld <= res;
            if (state == UPD && ch == CH_RGHT) rght_ld <= res;
        end
    end

`ifdef A2D_SCHED_BATT_FILT_EN
    a2d_batt_filt #(
        .BATT_THRES(BATT_THRES)
    ) u_filt (
        .clk(clk),
        .rst(rst),
        .wr (batt_wr),
        .smp(res),
        .avg(batt),
        .low(batt_low)
    );
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            batt     <= 12'hFFF;
            batt_low <= 1'b0;
        end else if (batt_wr) begin
            batt     <= res;
            batt_low <= (res < BATT_THRES);
        end
    end
`endif

endmodule

// File: tb/tb_a2d_sched.sv
// Randomized self-checking bench for a2d_sched against a channel-level model.
module tb_a2d_sched;

    localparam logic [11:0] THRES = 12'h800;
    localparam int          GAP   = 4;

    logic        clk = 1'b0;
    logic        rst, nxt, done;
    logic [15:0] rd_data;
    logic        wrt, batt_low, busy;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, batt;

    always #5 clk = ~clk;

    a2d_sched #(.BATT_THRES(THRES), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .nxt(nxt), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .batt(batt), .batt_low(batt_low), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int wrt_cnt = 0;
    logic [15:0] last_cmd;

    always @(negedge clk) if (wrt === 1'b1) wrt_cnt++;

    // Reference model: channel index into {lft, rght, batt} round robin
    int          idx;
    logic [11:0] m_lft, m_rght, m_batt;
    logic        m_low;
    logic [11:0] smp [4];

    function automatic logic [15:0] m_cmd();
        int c;
        c = (idx == 0) ? 0 : (idx == 1) ? 4 : 5;
        return 16'(c * 2048);
    endfunction

    task automatic model_reset();
        idx = 0;
        m_lft = 12'h000; m_rght = 12'h000; m_batt = 12'hFFF; m_low = 1'b0;
        for (int i = 0; i < 4; i++) smp[i] = 12'hFFF;
    endtask

    task automatic model_write(input logic [11:0] val);
        int sum;
        if (idx == 0) m_lft = val;
        else if (idx == 1) m_rght = val;
        else begin
`ifdef A2D_SCHED_BATT_FILT_EN
            for (int i = 3; i > 0; i--) smp[i] = smp[i-1];
            smp[0] = val;
            sum = smp[0] + smp[1] + smp[2] + smp[3];
            m_batt = 12'(sum / 4);
`else
            sum = 0;
            m_batt = val;
`endif
            m_low = (m_batt < THRES);
        end
        idx = (idx + 1) % 3;
    endtask

    task automatic check_regs(input string tag);
        n_cmp++;
        if (lft_ld !== m_lft || rght_ld !== m_rght ||
            batt !== m_batt || batt_low !== m_low) begin
            n_err++;
            $display("FAIL %s regs: got lft=%h rght=%h batt=%h low=%b want %h %h %h %b",
                     tag, lft_ld, rght_ld, batt, batt_low,
                     m_lft, m_rght, m_batt, m_low);
        end
    endtask

    task automatic conv(input logic [11:0] val, input bit dup, input bit same_done,
                        input int d1, input int d2);
        int w0, k;
        logic [15:0] ec;
        ec = m_cmd();
        w0 = wrt_cnt;
        nxt = 1'b1; done = same_done; rd_data = 16'($urandom);
        @(negedge clk);
        nxt = 1'b0; done = 1'b0;
        last_cmd = cmd;
        n_cmp++;
        if (wrt !== 1'b1 || cmd !== ec || busy !== 1'b1) begin
            n_err++;
            $display("FAIL tx1: got wrt=%b cmd=%h busy=%b want 1 %h 1", wrt, cmd, busy, ec);
        end
        if (dup) nxt = 1'b1;
        repeat (d1) begin
            @(negedge clk);
            nxt = 1'b0;
        end
        done = 1'b1; rd_data = 16'($urandom);
        @(negedge clk);
        done = 1'b0;
        k = 1;
        while (wrt !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k != GAP + 1 || cmd !== ec || busy !== 1'b1) begin
            n_err++;
            $display("FAIL gap: got done-to-wrt=%0d cmd=%h busy=%b want %0d %h 1",
                     k, cmd, busy, GAP + 1, ec);
        end
        repeat (d2) @(negedge clk);
        rd_data = {4'($urandom), val}; done = 1'b1;
        @(negedge clk);
        done = 1'b0; rd_data = 16'($urandom);
        n_cmp++;
        if (busy !== 1'b1 || wrt !== 1'b0 || cmd !== ec) begin
            n_err++;
            $display("FAIL upd: got busy=%b wrt=%b cmd=%h want 1 0 %h", busy, wrt, cmd, ec);
        end
        @(negedge clk);
        model_write(val);
        n_cmp++;
        if (busy !== 1'b0 || wrt_cnt - w0 != 2) begin
            n_err++;
            $display("FAIL end: got busy=%b wrt_pulses=%0d want 0 2", busy, wrt_cnt - w0);
        end
        check_regs("conv");
    endtask

    task automatic test_reset();
        rst = 1'b1; nxt = 1'b0; done = 1'b0; rd_data = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (wrt !== 1'b0 || cmd !== 16'h0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got wrt=%b cmd=%h busy=%b want 0 0000 0", wrt, cmd, busy);
        end
        check_regs("reset");
    endtask

    task automatic test_vectors();
        logic [15:0] want [3];
        logic [11:0] vals [3];
        want = '{16'h0000, 16'h2000, 16'h2800};
        vals = '{12'h123, 12'h456, 12'h789};
        for (int i = 0; i < 3; i++) begin
            conv(vals[i], 1'b0, 1'b0, 2, 1);
            n_cmp++;
            if (last_cmd !== want[i]) begin
                n_err++;
                $display("FAIL vec_cmd%0d: got %h want %h", i, last_cmd, want[i]);
            end
        end
        n_cmp++;
        if (lft_ld !== 12'h123 || rght_ld !== 12'h456 || batt_low !== 1'b1) begin
            n_err++;
            $display("FAIL vec_res: got lft=%h rght=%h low=%b want 123 456 1",
                     lft_ld, rght_ld, batt_low);
        end
    endtask

    task automatic test_threshold();
        logic [11:0] tv [2];
        tv = '{12'h800, 12'h7FF};
        for (int i = 0; i < 2; i++) begin
            conv(12'($urandom), 1'b0, 1'b0, 1, 0);
            conv(12'($urandom), 1'b0, 1'b0, 1, 0);
            conv(tv[i], 1'b0, 1'b0, 1, 0);
`ifndef A2D_SCHED_BATT_FILT_EN
            n_cmp++;
            if (batt !== tv[i] || batt_low !== (i == 1)) begin
                n_err++;
                $display("FAIL thres%0d: got batt=%h low=%b want %h %b",
                         i, batt, batt_low, tv[i], (i == 1));
            end
`endif
        end
    endtask

    task automatic test_dup_nxt();
        conv(12'($urandom), 1'b1, 1'b0, 3, 2);
        conv(12'($urandom), 1'b0, 1'b1, 1, 1);
    endtask

    task automatic test_abort();
        rd_data = 16'($urandom);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (busy !== 1'b0 || cmd !== 16'h0000) begin
            n_err++;
            $display("FAIL abort: got busy=%b cmd=%h want 0 0000", busy, cmd);
        end
        repeat (3) begin
            done = 1'b1; rd_data = 16'($urandom);
            @(negedge clk);
            done = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (busy !== 1'b0 || wrt_cnt < 0) begin
            n_err++;
            $display("FAIL stray_done: got busy=%b want 0", busy);
        end
        check_regs("abort");
        conv(12'($urandom), 1'b0, 1'b0, 1, 1);
        n_cmp++;
        if (last_cmd !== 16'h0000) begin
            n_err++;
            $display("FAIL abort_cmd: got %h want 0000", last_cmd);
        end
    endtask

`ifdef A2D_SCHED_BATT_FILT_EN
    task automatic test_filter();
        logic [11:0] want [4];
        want = '{12'hCFF, 12'h9FF, 12'h6FF, 12'h400};
        test_reset();
        for (int i = 0; i < 4; i++) begin
            conv(12'($urandom), 1'b0, 1'b0, 1, 0);
            conv(12'($urandom), 1'b0, 1'b0, 1, 0);
            conv(12'h400, 1'b0, 1'b0, 1, 0);
            n_cmp++;
            if (batt !== want[i]) begin
                n_err++;
                $display("FAIL filt%0d: got %h want %h", i, batt, want[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [11:0] v;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) == 0) ? 12'(THRES - 12'd1 + 12'($urandom_range(0, 2)))
                                            : 12'($urandom);
            conv(v, 1'($urandom), 1'($urandom), $urandom_range(1, 5), $urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_vectors();
        test_threshold();
        test_dup_nxt();
        test_abort();
`ifdef A2D_SCHED_BATT_FILT_EN
        test_filter();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
